// File: rtl/pipe_pc_ctrl.sv
// Fetch-stage PC controller: owns the PC register, arbitrates redirect sources and defers them across stalls.
// Optional macro DELAY_SLOT_EN: j/r/b redirects leave the delay-slot instruction in IF/ID (no flush).
module pipe_pc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter logic [31:0] EXC_ADDR = 32'h0040_0004
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic        b_req,
  input  logic        r_req,
  input  logic        j_req,
  input  logic [31:0] npc,
  output logic [31:0] pc,
  output logic [2:0]  pc_mux_sel,
  output logic        if_id_we,
  output logic        if_id_flush,
  output logic        redirect_pend
);

  localparam logic [2:0] SEL_J    = 3'd0;
  localparam logic [2:0] SEL_R    = 3'd1;
  localparam logic [2:0] SEL_SEQ  = 3'd2;
  localparam logic [2:0] SEL_EXC  = 3'd3;
  localparam logic [2:0] SEL_B    = 3'd4;
  localparam logic [2:0] SEL_ERET = 3'd5;

  typedef enum logic [1:0] {BOOT, RUN, PEND} state_e;

  if (RESET_PC[1:0] != 2'b00 || EXC_ADDR[1:0] != 2'b00) begin : g_align_chk
    $error("pipe_pc_ctrl: RESET_PC and EXC_ADDR must be word aligned");
  end

  state_e      state_q, state_d;
  logic [31:0] pc_q;
  logic [2:0]  pend_sel_q, pend_sel_d;
  logic [2:0]  req_sel, cand_sel;
  logic        req_vld, cand_vld, load;

  // Deferrable sources only; exception is handled outside the ranking.
  function automatic logic [2:0] rank(input logic [2:0] sel);
    case (sel)
      SEL_ERET: rank = 3'd4;
      SEL_B:    rank = 3'd3;
      SEL_R:    rank = 3'd2;
      SEL_J:    rank = 3'd1;
      default:  rank = 3'd0;
    endcase
  endfunction

  always_comb begin
    req_vld = 1'b1;
    req_sel = SEL_SEQ;
    if (eret_req)   req_sel = SEL_ERET;
    else if (b_req) req_sel = SEL_B;
    else if (r_req) req_sel = SEL_R;
    else if (j_req) req_sel = SEL_J;
    else            req_vld = 1'b0;

    // Candidate redirect: the held one, unless a strictly higher-ranked request shows up.
    cand_vld = (state_q == PEND);
    cand_sel = pend_sel_q;
    if (req_vld && (!cand_vld || rank(req_sel) > rank(cand_sel))) begin
      cand_vld = 1'b1;
      cand_sel = req_sel;
    end

    state_d     = state_q;
    pend_sel_d  = pend_sel_q;
    pc_mux_sel  = SEL_SEQ;
    if_id_we    = 1'b0;
    if_id_flush = 1'b0;
    load        = 1'b0;

    case (state_q)
      BOOT: begin
        if_id_flush = 1'b1;
        state_d     = RUN;
      end
      default: begin
        if_id_we = !stall;
        if (exc_req) begin
          pc_mux_sel = SEL_EXC;
          load       = 1'b1;
          state_d    = RUN;
        end else if (stall) begin
          if (cand_vld) begin
            pend_sel_d = cand_sel;
            state_d    = PEND;
          end
        end else begin
          load    = 1'b1;
          state_d = RUN;
          if (cand_vld) pc_mux_sel = cand_sel;
        end
        if (pc_mux_sel == SEL_EXC || pc_mux_sel == SEL_ERET) begin
          if_id_flush = 1'b1;
        end else if (pc_mux_sel != SEL_SEQ) begin
`ifdef DELAY_SLOT_EN
          if_id_flush = 1'b0;
`else
          if_id_flush = 1'b1;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      pend_sel_q <= SEL_SEQ;
    end else begin
      state_q    <= state_d;
      pend_sel_q <= pend_sel_d;
      if (load) pc_q <= npc;
    end
  end

  assign pc            = pc_q;
  assign redirect_pend = (state_q == PEND);

endmodule

// File: tb/tb_pipe_pc_ctrl.sv
// Bench for pipe_pc_ctrl: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a priority-list reference model.
module tb_pipe_pc_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;
  localparam logic [31:0] EXC_ADDR = 32'h0040_0004;
`ifdef DELAY_SLOT_EN
  localparam logic DSE = 1'b1;
`else
  localparam logic DSE = 1'b0;
`endif

  logic        clk = 1'b1;
  logic        rst_n = 1'b0, stall = 1'b0, exc_req = 1'b0, eret_req = 1'b0;
  logic        b_req = 1'b0, r_req = 1'b0, j_req = 1'b0;
  logic [31:0] npc = '0;
  logic [31:0] pc;
  logic [2:0]  pc_mux_sel;
  logic        if_id_we, if_id_flush, redirect_pend;

  pipe_pc_ctrl #(.RESET_PC(RESET_PC), .EXC_ADDR(EXC_ADDR)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .exc_req(exc_req), .eret_req(eret_req),
    .b_req(b_req), .r_req(r_req), .j_req(j_req), .npc(npc), .pc(pc),
    .pc_mux_sel(pc_mux_sel), .if_id_we(if_id_we), .if_id_flush(if_id_flush),
    .redirect_pend(redirect_pend)
  );

  always #5 clk = ~clk;

  int unsigned vectors = 0, miscompares = 0, compares = 0;

  // Reference model state: phase -1 unknown, 0 boot, 1 run, 2 holding m_pend.
  int          m_phase = -1;
  int          m_pend  = -1;
  logic [31:0] m_pc    = '0;
  logic [31:0] tgt [6];
  logic [2:0]  s_sel;
  logic        s_we, s_flush;

  function automatic int prio(input int code);
    case (code)
      3: return 5;
      5: return 4;
      4: return 3;
      1: return 2;
      0: return 1;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compares++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic rst, input logic stl, input logic exc, input logic eret,
                      input logic b, input logic r, input logic j);
    logic reqs [6];
    int   order [5] = '{3, 5, 4, 1, 0};
    int   win, cand, applied;
    logic e_we, e_flush, loads;
    rst_n = rst; stall = stl; exc_req = exc; eret_req = eret; b_req = b; r_req = r; j_req = j;
    reqs = '{j, r, 1'b0, exc, b, eret};
    win = -1;
    foreach (order[k]) if (win < 0 && reqs[order[k]]) win = order[k];
    tgt[2] = m_pc + 32'd4;
    tgt[3] = EXC_ADDR;

    applied = 2; e_we = 1'b0; e_flush = 1'b1; loads = 1'b0;
    cand = m_pend;
    if (m_phase >= 1) begin
      e_we = !stl;
      if (win == 3) begin
        applied = 3; loads = 1'b1; cand = -1;
      end else begin
        if (prio(win) > prio(cand)) cand = win;
        if (!stl) begin
          if (cand >= 0) applied = cand;
          loads = 1'b1; cand = -1;
        end
      end
      e_flush = (applied != 2) && (applied == 3 || applied == 5 || !DSE);
    end
    npc = tgt[applied];

    @(negedge clk);
    vectors++;
    s_sel = pc_mux_sel; s_we = if_id_we; s_flush = if_id_flush;
    if (m_phase >= 0) begin
      chk("pc_mux_sel", {29'd0, pc_mux_sel}, applied[31:0]);
      chk("if_id_we", {31'd0, if_id_we}, {31'd0, e_we});
      chk("if_id_flush", {31'd0, if_id_flush}, {31'd0, e_flush});
    end

    @(posedge clk);
    if (!rst) begin
      m_phase = 0; m_pc = RESET_PC; m_pend = -1;
    end else if (m_phase == 0) begin
      m_phase = 1;
    end else if (m_phase > 0) begin
      if (loads) m_pc = tgt[applied];
      m_pend  = cand;
      m_phase = (cand >= 0) ? 2 : 1;
    end
    #1;
    chk("pc", pc, m_pc);
    chk("redirect_pend", {31'd0, redirect_pend}, {31'd0, m_phase == 2});
  endtask

  initial begin
    tgt[0] = 32'h1000_0000; tgt[1] = 32'h2000_0000;
    tgt[4] = 32'h3000_0000; tgt[5] = 32'h4000_0000;

    // Reset for two cycles, then BOOT, then sequential fetch
    step(0,0,0,0,0,0,0);
    step(0,0,0,0,0,0,0);
    chk("lit_rst_pc", pc, 32'h0040_0000);
    chk("lit_rst_we", {31'd0, s_we}, 32'd0);
    chk("lit_rst_flush", {31'd0, s_flush}, 32'd1);
    chk("lit_rst_pend", {31'd0, redirect_pend}, 32'd0);
    step(1,0,0,0,0,0,0);
    chk("lit_boot_we", {31'd0, s_we}, 32'd0);
    chk("lit_boot_sel", {29'd0, s_sel}, 32'd2);
    chk("lit_boot_pc", pc, 32'h0040_0000);
    step(1,0,0,0,0,0,0);
    chk("lit_seq_we", {31'd0, s_we}, 32'd1);
    chk("lit_seq_pc", pc, 32'h0040_0004);

    // b and j together: branch wins
    step(1,0,0,0,1,0,1);
    chk("lit_bj_sel", {29'd0, s_sel}, 32'd4);
    chk("lit_bj_flush", {31'd0, s_flush}, DSE ? 32'd0 : 32'd1);
    chk("lit_bj_pc", pc, 32'h3000_0000);

    // Stall 3 cycles with j in the first
    step(1,1,0,0,0,0,1);
    chk("lit_st1_pend", {31'd0, redirect_pend}, 32'd1);
    step(1,1,0,0,0,0,0);
    chk("lit_st2_pc", pc, 32'h3000_0000);
    step(1,1,0,0,0,0,0);
    chk("lit_st3_pend", {31'd0, redirect_pend}, 32'd1);
    step(1,0,0,0,0,0,0);
    chk("lit_rel_sel", {29'd0, s_sel}, 32'd0);
    chk("lit_rel_pc", pc, 32'h1000_0000);

    // Pending r replaced by b, later j dropped
    step(1,1,0,0,0,1,0);
    step(1,1,0,0,1,0,0);
    step(1,1,0,0,0,0,1);
    step(1,0,0,0,0,0,0);
    chk("lit_repl_sel", {29'd0, s_sel}, 32'd4);
    chk("lit_repl_pc", pc, 32'h3000_0000);

    // Exception while stalled with pending j
    step(1,1,0,0,0,0,1);
    step(1,1,1,0,0,0,0);
    chk("lit_exc_sel", {29'd0, s_sel}, 32'd3);
    chk("lit_exc_flush", {31'd0, s_flush}, 32'd1);
    chk("lit_exc_pc", pc, 32'h0040_0004);
    chk("lit_exc_pend", {31'd0, redirect_pend}, 32'd0);
    step(1,0,0,0,0,0,0);
    chk("lit_exc_nojump", {29'd0, s_sel}, 32'd2);

    // eret, and eret together with exception
    step(1,0,0,1,0,0,0);
    chk("lit_eret_sel", {29'd0, s_sel}, 32'd5);
    chk("lit_eret_flush", {31'd0, s_flush}, 32'd1);
    chk("lit_eret_pc", pc, 32'h4000_0000);
    step(1,0,1,1,0,0,0);
    chk("lit_exc_eret_sel", {29'd0, s_sel}, 32'd3);

    // Randomized traffic, occasional mid-run reset
    for (int unsigned n = 0; n < 3000; n++) begin
      tgt[0] = $urandom & 32'hFFFF_FFFC;
      tgt[1] = $urandom & 32'hFFFF_FFFC;
      tgt[4] = $urandom & 32'hFFFF_FFFC;
      tgt[5] = $urandom & 32'hFFFF_FFFC;
      step($urandom_range(99) != 0, $urandom_range(9) < 4, $urandom_range(19) == 0,
           $urandom_range(9) == 0, $urandom_range(6) == 0, $urandom_range(6) == 0,
           $urandom_range(6) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
